// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared memory port: grants instruction fetch (port 0)
// or data access (port 1), drives the steering mux select and aborts hung accesses.
module mem_port_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4,
    parameter bit FIX_PRI = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       MEM_ACK,
    output logic       SEL,
    output logic       MEM_EN,
    output logic       GNT0,
    output logic       GNT1,
    output logic       DONE0,
    output logic       DONE1,
    output logic       ERR,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prio_q, prio_d;    // 1 = port 1 wins the next tie
    logic             sel_q, sel_d;
    logic             mem_en_q, mem_en_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             err_q, err_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prio_q   <= 1'b0;
            sel_q    <= 1'b0;
            mem_en_q <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prio_q   <= prio_d;
            sel_q    <= sel_d;
            mem_en_q <= mem_en_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (REQ0 && REQ1) begin
                    state_d = (FIX_PRI || !prio_q) ? BUSY0 : BUSY1;
                end else if (REQ0) begin
                    state_d = BUSY0;
                end else if (REQ1) begin
                    state_d = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                // An ACK on the last allowed cycle still counts as completion.
                if (MEM_ACK || (cnt_q == LAST_CNT)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    prio_d  = (state_q == BUSY0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_comb begin
        gnt0_d   = (state_d == BUSY0);
        gnt1_d   = (state_d == BUSY1);
        mem_en_d = (state_d != IDLE);
        sel_d    = sel_q;
        if (state_d == BUSY0) begin
            sel_d = 1'b0;
        end else if (state_d == BUSY1) begin
            sel_d = 1'b1;
        end
        done0_d = (state_q == BUSY0) && MEM_ACK;
        done1_d = (state_q == BUSY1) && MEM_ACK;
        err_d   = (state_q != IDLE) && !MEM_ACK && (cnt_q == LAST_CNT);
    end

    assign SEL       = sel_q;
    assign MEM_EN    = mem_en_q;
    assign GNT0      = gnt0_q;
    assign GNT1      = gnt1_q;
    assign DONE0     = done0_q;
    assign DONE1     = done1_q;
    assign ERR       = err_q;
    assign state_dbg = state_q;

endmodule
